// File: rtl/fetch_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : fetch_pkg                                                    |
// | Purpose : Shared types and constants for the instruction prefetch unit |
// |           (fetch FSM state encoding, PC increment).                    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package fetch_pkg;

  // IDLE : nothing outstanding
  // WAIT : one request outstanding, its response will be buffered
  // DROP : one request outstanding, its response will be discarded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_INC = 4;

endpackage
`default_nettype wire

// File: rtl/prefetch_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : prefetch_unit_if                                           |
// | Purpose   : Bundles the redirect input, the instruction-memory         |
// |             request/response channel and the consumer output channel.  |
// | Modports  : master - the prefetch unit                                 |
// |             slave  - the environment (memory, consumer, branch unit)   |
// | Rev       : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface prefetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) ();

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  logic               mem_req_valid;
  logic [ADDR_W-1:0]  mem_req_addr;
  logic               mem_req_ready;
  logic               mem_rsp_valid;
  logic [INSTR_W-1:0] mem_rsp_data;

  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output out_valid, out_instr, out_pc,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  out_valid, out_instr, out_pc,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : fetch_fifo                                                   |
// | Purpose : Small synchronous FIFO holding {pc, instruction} entries.    |
// | Ports   : clk, reset_n (async, active-low), flush (sync clear),        |
// |           push/push_data, pop, head_data, not_empty, full              |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             flush,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] head_data,
  output logic                  not_empty,
  output logic                  full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign full      = (count == DEPTH_CNT);
  assign head_data = mem[rd_ptr];

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle; pointers wrap naturally because DEPTH is a power of two.
  assign do_pop  = pop && not_empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads as zero while in reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/prefetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : prefetch_unit                                                |
// | Purpose : Sequential instruction prefetcher with a single outstanding  |
// |           memory request, redirect support and an in-order buffer.     |
// | Ports   : clk, reset_n (async, active-low),                            |
// |           bus (prefetch_unit_if.master): redirect, memory req/rsp,     |
// |           consumer output channel                                      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 4
) (
  input wire logic        clk,
  input wire logic        reset_n,
  prefetch_unit_if.master bus
);

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [ADDR_W-1:0]     fpc;
  logic [ADDR_W-1:0]     req_pc;
  logic                  accept;
  logic                  redirect;
  logic                  push;
  logic                  pop;
  logic                  fifo_valid;
  logic                  fifo_full;
  logic [ADDR_W+INSTR_W-1:0] head;

  assign redirect = bus.redirect_valid;

  // A request may only go out from IDLE, where no slot is reserved, so a
  // single free slot is enough. The reset gate keeps the request low while
  // reset is held (state already reads IDLE then).
  assign bus.mem_req_valid = reset_n && (state == IDLE) && !fifo_full;
  assign bus.mem_req_addr  = fpc;
  assign accept            = bus.mem_req_valid && bus.mem_req_ready;

  // Redirect outranks buffering the response and popping the head.
  assign push = (state == WAIT) && bus.mem_rsp_valid && !redirect;
  assign pop  = bus.out_ready && fifo_valid && !redirect;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = redirect ? DROP : WAIT;
      WAIT: begin
        if (bus.mem_rsp_valid)  state_next = IDLE;
        else if (redirect)      state_next = DROP;
      end
      DROP: if (bus.mem_rsp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      fpc    <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        fpc <= bus.redirect_pc;
      end else if (accept) begin
        fpc <= fpc + ADDR_W'(PC_INC);
      end
      if (accept) begin
        req_pc <= fpc;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (push),
    .push_data ({req_pc, bus.mem_rsp_data}),
    .pop       (pop),
    .head_data (head),
    .not_empty (fifo_valid),
    .full      (fifo_full)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_pc    = head[ADDR_W+INSTR_W-1:INSTR_W];
  assign bus.out_instr = head[INSTR_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_prefetch_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_prefetch_unit                                             |
// | Purpose : Self-checking bench for prefetch_unit: memory responder with |
// |           variable latency, randomized handshakes/redirects, and a     |
// |           stream-level reference model of expected fetch/output PCs.   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_prefetch_unit;

  localparam int          ADDR_W   = 32;
  localparam int          INSTR_W  = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  prefetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  prefetch_unit #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  // Memory responder state (one slot: the spec allows one outstanding).
  logic        pend = 1'b0;
  logic        stale = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;

  // Reference model: next expected request address and next expected output PC.
  logic [31:0] exp_req = RESET_PC;
  logic [31:0] exp_out = RESET_PC;

  // Stimulus controls.
  int          rst_cycles = 3;
  int          rdy_mode = 1;     // 0 random, 1 always, 2 never
  int          ordy_mode = 1;
  int          lat_fixed = 1;    // 0 random 1..4
  int          redir_prob = 0;   // 0 none, else 1-in-N
  logic        force_redir = 1'b0;
  logic [31:0] force_target = '0;
  logic        coinc_arm = 1'b0;
  logic        coinc_hit = 1'b0;
  logic [31:0] coinc_target = '0;

  // Previous-cycle observations for stability checks.
  logic        prev_redirect = 1'b0;
  logic        prev_out_hold = 1'b0;
  logic [31:0] prev_out_pc = '0;
  logic [31:0] prev_out_instr = '0;
  logic        prev_req_hold = 1'b0;
  logic [31:0] prev_req_addr = '0;

  int          pops = 0;
  logic [31:0] acc_log[$];
  logic [31:0] pop_log[$];

  task automatic cycle();
    logic        rsp_now;
    logic        redir;
    logic [31:0] tgt;
    @(negedge clk);
    reset_n = (rst_cycles == 0);
    if (rst_cycles > 0) rst_cycles--;

    rsp_now = 1'b0;
    if (pend) begin
      if (pend_cnt <= 1) rsp_now = 1'b1;
      else pend_cnt--;
    end
    bus.mem_rsp_valid = rsp_now;
    bus.mem_rsp_data  = rsp_now ? mem_word(pend_addr) : $urandom;
    bus.mem_req_ready = stale ? 1'b0 :
                        (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    bus.out_ready     = (ordy_mode == 0) ? ($urandom_range(0, 9) < 6) : (ordy_mode == 1);

    redir = 1'b0;
    tgt   = $urandom & 32'hFFFF_FFFC;
    if (redir_prob != 0 && $urandom_range(0, redir_prob - 1) == 0) redir = 1'b1;
    if (force_redir) begin
      redir = 1'b1;
      tgt = force_target;
      force_redir = 1'b0;
    end
    if (coinc_arm && rsp_now && bus.out_valid) begin
      redir = 1'b1;
      tgt = coinc_target;
      bus.out_ready = 1'b1;
      coinc_arm = 1'b0;
      coinc_hit = 1'b1;
    end
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;

    #2;
    if (!reset_n) begin
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_req_valid", bus.mem_req_valid, 0);
      check("rst_out_pc", bus.out_pc, 0);
      check("rst_out_instr", bus.out_instr, 0);
      exp_req = RESET_PC;
      exp_out = RESET_PC;
      if (pend) stale = 1'b1;
      if (rsp_now) begin
        pend = 1'b0;
        stale = 1'b0;
      end
      prev_redirect = 1'b0;
      prev_out_hold = 1'b0;
      prev_req_hold = 1'b0;
      return;
    end

    if (prev_redirect) check("flush_out_valid", bus.out_valid, 0);
    if (prev_out_hold) begin
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_out_pc", bus.out_pc, prev_out_pc);
      check("hold_out_instr", bus.out_instr, prev_out_instr);
    end
    if (prev_req_hold) begin
      check("hold_req_valid", bus.mem_req_valid, 1);
      check("hold_req_addr", bus.mem_req_addr, prev_req_addr);
    end
    if (bus.mem_req_valid) begin
      check("req_addr", bus.mem_req_addr, exp_req);
      if (!stale) check("one_outstanding", pend, 0);
    end

    if (bus.out_valid && bus.out_ready && !redir) begin
      check("out_pc", bus.out_pc, exp_out);
      check("out_instr", bus.out_instr, mem_word(exp_out));
      pop_log.push_back(bus.out_pc);
      exp_out = exp_out + 32'd4;
      pops++;
    end

    if (rsp_now) begin
      pend = 1'b0;
      stale = 1'b0;
    end
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      acc_log.push_back(bus.mem_req_addr);
      pend      = 1'b1;
      pend_addr = bus.mem_req_addr;
      pend_cnt  = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
      exp_req   = bus.mem_req_addr + 32'd4;
    end
    if (redir) begin
      exp_req = tgt;
      exp_out = tgt;
    end

    prev_redirect  = redir;
    prev_out_hold  = bus.out_valid && !bus.out_ready && !redir;
    prev_out_pc    = bus.out_pc;
    prev_out_instr = bus.out_instr;
    prev_req_hold  = bus.mem_req_valid && !bus.mem_req_ready && !redir;
    prev_req_addr  = bus.mem_req_addr;
  endtask

  function automatic logic [31:0] log_at(input logic [31:0] q[$], input int idx);
    return (idx < q.size()) ? q[idx] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    int pops_before;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_rsp_valid  = 1'b0;
    bus.mem_rsp_data   = '0;
    bus.out_ready      = 1'b0;

    // Reset, then streaming fetch with latency 1.
    repeat (3) cycle();
    cycle();
    check("first_req_count", acc_log.size(), 1);
    check("first_req_addr", log_at(acc_log, 0), RESET_PC);
    repeat (20) cycle();
    check("s037_pop0", log_at(pop_log, 0), 32'h0);
    check("s037_pop1", log_at(pop_log, 1), 32'h4);
    check("s037_pop2", log_at(pop_log, 2), 32'h8);

    // Consumer stalled: buffer fills to DEPTH and requests stop.
    ordy_mode = 2;
    force_redir = 1'b1;
    force_target = 32'h200;
    cycle();
    acc_log.delete();
    repeat (30) cycle();
    check("s038_accepts", acc_log.size(), DEPTH);
    check("s038_req_idle", bus.mem_req_valid, 0);
    check("s038_out_valid", bus.out_valid, 1);
    ordy_mode = 1;
    pop_log.delete();
    repeat (20) cycle();
    check("s038_pop0", log_at(pop_log, 0), 32'h200);
    check("s038_pop3", log_at(pop_log, 3), 32'h20C);

    // Redirect while a latency-3 request is outstanding.
    lat_fixed = 3;
    acc_log.delete();
    for (int i = 0; i < 20 && acc_log.size() == 0; i++) cycle();
    check("s039_accept_seen", acc_log.size() > 0, 1);
    force_redir = 1'b1;
    force_target = 32'h100;
    cycle();
    pop_log.delete();
    repeat (20) cycle();
    check("s039_pop0", log_at(pop_log, 0), 32'h100);

    // Redirect coincident with a pop and a response.
    lat_fixed = 2;
    ordy_mode = 2;
    repeat (15) cycle();
    ordy_mode = 1;
    coinc_hit = 1'b0;
    coinc_arm = 1'b1;
    coinc_target = 32'h300;
    for (int i = 0; i < 30 && !coinc_hit; i++) cycle();
    coinc_arm = 1'b0;
    check("s040_hit", coinc_hit, 1);
    cycle();
    check("s040_empty", bus.out_valid, 0);
    pop_log.delete();
    repeat (20) cycle();
    check("s040_pop0", log_at(pop_log, 0), 32'h300);

    // Address wrap.
    lat_fixed = 0;
    force_redir = 1'b1;
    force_target = 32'hFFFF_FFF8;
    cycle();
    acc_log.delete();
    repeat (30) cycle();
    check("s041_acc0", log_at(acc_log, 0), 32'hFFFF_FFF8);
    check("s041_acc1", log_at(acc_log, 1), 32'hFFFF_FFFC);
    check("s041_acc2", log_at(acc_log, 2), 32'h0000_0000);

    // Reset pulse while WAIT, late response must be ignored.
    lat_fixed = 3;
    repeat (10) cycle();
    acc_log.delete();
    for (int i = 0; i < 20 && acc_log.size() == 0; i++) cycle();
    check("s042_accept_seen", acc_log.size() > 0, 1);
    pop_log.delete();
    rst_cycles = 1;
    repeat (30) cycle();
    check("s042_stale_done", stale, 0);
    check("s042_pop0", log_at(pop_log, 0), RESET_PC);
    check("s042_pop1", log_at(pop_log, 1), RESET_PC + 32'd4);

    // Randomized traffic.
    lat_fixed = 0;
    rdy_mode = 0;
    ordy_mode = 0;
    redir_prob = 20;
    repeat (1500) cycle();
    redir_prob = 0;
    rdy_mode = 1;
    ordy_mode = 1;
    pops_before = pops;
    repeat (30) cycle();
    check("liveness_pops", pops > pops_before, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
